vga_timing_gen: RTL and testbench

Pixel-clock raster timing generator for the VGA output path, sitting directly upstream of the pixel stage. Each `clk_25` cycle it walks a horizontal/vertical counter pair across a 640x480@60 raster (800x525 total). It produces registered sync pulses, a display-enable flag aligned to the counters, and per-line/per-frame markers plus a frame counter. Downstream logic colours the pixel from `counter_x`/`counter_y` and blanks it when `in_display_area` is low.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 35 +++
 rtl/vga_timing_gen.sv | 93 +++++++++
 tb/tb_vga_timing_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants and helpers for the VGA timing path.
package vga_timing_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned COORD_LIMIT = 1 << COORD_W;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;

    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    function automatic int unsigned h_total(input int unsigned visible, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return visible + front + sync + back;
    endfunction

    function automatic int unsigned v_total(input int unsigned visible, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping raster-axis counter with a terminal-count flag and its next value.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned MAX = 800
) (
    input  logic               clk_25,
    input  logic               rst,
    input  logic               en,
    output logic [COORD_W-1:0] count,
    output logic [COORD_W-1:0] count_next,
    output logic               tc
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(MAX - 1);

    // Terminal count and the value the counter takes at the next edge.
    always_comb begin
        tc         = (count == LAST);
        count_next = count;
        if (en) begin
            count_next = tc ? '0 : count + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counters, sync pulses, display enable and markers.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT     = DEF_H_FRONT,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic               clk_25,
    input  logic               rst,
    output logic [COORD_W-1:0] counter_x,
    output logic [COORD_W-1:0] counter_y,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               in_display_area,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_count
);

    localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > COORD_LIMIT) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL exceeds coordinate range");
    end
    if (V_TOTAL > COORD_LIMIT) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL exceeds coordinate range");
    end

    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic               x_tc;
    logic               y_tc;
    logic               frame_wrap;

    vga_axis_counter #(
        .MAX (H_TOTAL)
    ) u_x_counter (
        .clk_25     (clk_25),
        .rst        (rst),
        .en         (1'b1),
        .count      (counter_x),
        .count_next (x_next),
        .tc         (x_tc)
    );

    vga_axis_counter #(
        .MAX (V_TOTAL)
    ) u_y_counter (
        .clk_25     (clk_25),
        .rst        (rst),
        .en         (x_tc),
        .count      (counter_y),
        .count_next (y_next),
        .tc         (y_tc)
    );

    assign frame_wrap = x_tc & y_tc;

    // Decode from the next counter values so every registered output lines up with counter_x/counter_y.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            frame_count     <= '0;
            hsync_out       <= ~SYNC_ACTIVE;
            vsync_out       <= ~SYNC_ACTIVE;
            in_display_area <= 1'b1;
            line_start      <= 1'b0;
            frame_start     <= 1'b0;
        end else begin
            frame_count     <= frame_count + {7'd0, frame_wrap};
            hsync_out       <= (x_next >= HS_FIRST && x_next <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_out       <= (y_next >= VS_FIRST && y_next <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            in_display_area <= (x_next < H_VIS) && (y_next < V_VIS);
            line_start      <= (x_next == '0);
            frame_start     <= (x_next == '0) && (y_next == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default raster, short-frame raster and tiny raster.
module tb_vga_timing_gen;

    logic clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Default 640x480 instance
    logic       rst = 1'b1;
    logic [9:0] x, y;
    logic       hs, vs, de, ls, fs;
    logic [7:0] fc;

    vga_timing_gen dut (
        .clk_25 (clk_25), .rst (rst),
        .counter_x (x), .counter_y (y),
        .hsync_out (hs), .vsync_out (vs), .in_display_area (de),
        .line_start (ls), .frame_start (fs), .frame_count (fc)
    );

    // Default horizontal timing with a 30-line frame (20/4/2/4)
    logic       rst_m = 1'b1;
    logic [9:0] m_x, m_y;
    logic       m_hs, m_vs, m_de, m_ls, m_fs;
    logic [7:0] m_fc;

    vga_timing_gen #(
        .V_VISIBLE (20), .V_FRONT (4), .V_SYNC (2), .V_BACK (4)
    ) dut_m (
        .clk_25 (clk_25), .rst (rst_m),
        .counter_x (m_x), .counter_y (m_y),
        .hsync_out (m_hs), .vsync_out (m_vs), .in_display_area (m_de),
        .line_start (m_ls), .frame_start (m_fs), .frame_count (m_fc)
    );

    // Tiny raster: H 4/1/1/1 (7), V 2/1/1/1 (5)
    logic       rst_s = 1'b1;
    logic [9:0] s_x, s_y;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [7:0] s_fc;

    vga_timing_gen #(
        .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
        .V_VISIBLE (2), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
    ) dut_s (
        .clk_25 (clk_25), .rst (rst_s),
        .counter_x (s_x), .counter_y (s_y),
        .hsync_out (s_hs), .vsync_out (s_vs), .in_display_area (s_de),
        .line_start (s_ls), .frame_start (s_fs), .frame_count (s_fc)
    );

    task automatic check(input string tag, input int unsigned observed, input int unsigned expected);
        n_checks++;
        if (observed != expected) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_x"},  x,  0);
        check({tag, "_y"},  y,  0);
        check({tag, "_hs"}, hs, 1);
        check({tag, "_vs"}, vs, 1);
        check({tag, "_de"}, de, 1);
        check({tag, "_fc"}, fc, 0);
        check({tag, "_ls"}, ls, 0);
        check({tag, "_fs"}, fs, 0);
    endtask

    // Reference position for the tiny raster
    int unsigned sx, sy;
    logic [7:0]  sfc;

    task automatic small_step();
        step();
        sx++;
        if (sx == 7) begin
            sx = 0;
            sy++;
            if (sy == 5) begin
                sy = 0;
                sfc++;
            end
        end
        check("s_x",  s_x,  sx);
        check("s_y",  s_y,  sy);
        check("s_hs", s_hs, (sx == 5) ? 0 : 1);
        check("s_vs", s_vs, (sy == 3) ? 0 : 1);
        check("s_de", s_de, (sx < 4 && sy < 2) ? 1 : 0);
        check("s_ls", s_ls, (sx == 0) ? 1 : 0);
        check("s_fs", s_fs, (sx == 0 && sy == 0) ? 1 : 0);
        check("s_fc", s_fc, sfc);
    endtask

    initial begin
        int unsigned hs_low;
        int unsigned mx, my;

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_state("rst_hold");
        end
        rst = 1'b0;
        step();
        check("rel_x", x, 1);
        check("rel_y", y, 0);
        check("rel_ls", ls, 0);

        // One line: hsync and display-enable windows
        hs_low = 0;
        for (int i = 2; i <= 799; i++) begin
            step();
            check("line_x", x, i);
            check("line_hs", hs, (i >= 656 && i <= 751) ? 0 : 1);
            check("line_de", de, (i < 640) ? 1 : 0);
            if (hs == 1'b0) hs_low++;
        end
        check("hs_low_count", hs_low, 96);
        step();
        check("l1_x", x, 0);
        check("l1_y", y, 1);
        check("l1_ls", ls, 1);
        check("l1_fs", fs, 0);

        // Line wrap at (799,10)
        repeat (7999) step();
        check("pre_wrap_x", x, 799);
        check("pre_wrap_y", y, 10);
        step();
        check("wrap_x", x, 0);
        check("wrap_y", y, 11);
        check("wrap_ls", ls, 1);
        check("wrap_fs", fs, 0);
        check("wrap_fc", fc, 0);
        step();
        check("wrap_ls_drop", ls, 0);
        check("wrap_x1", x, 1);

        // Reset mid-frame at (300,12)
        repeat (1099) step();
        check("mid_x", x, 300);
        check("mid_y", y, 12);
        rst = 1'b1;
        step();
        check_reset_state("mid_rst");
        rst = 1'b0;
        step();
        check("mid_rel_x", x, 1);
        check("mid_rel_y", y, 0);
        check("mid_rel_ls", ls, 0);
        check("mid_rel_fs", fs, 0);
        rst = 1'b1;

        // Frame wrap on the 30-line raster
        rst_m = 1'b0;
        step();
        check("m_rel_x", m_x, 1);
        check("m_rel_y", m_y, 0);
        mx = 1;
        my = 0;
        for (int i = 0; i < 23998; i++) begin
            step();
            mx++;
            if (mx == 800) begin
                mx = 0;
                my++;
            end
            if (mx == 0) begin
                check("m_line_y", m_y, my);
                check("m_line_ls", m_ls, 1);
                check("m_line_vs", m_vs, (my >= 24 && my <= 25) ? 0 : 1);
                check("m_line_de", m_de, (my < 20) ? 1 : 0);
            end
        end
        check("m_pre_x", m_x, 799);
        check("m_pre_y", m_y, 29);
        check("m_pre_fc", m_fc, 0);
        step();
        check("m_wrap_x", m_x, 0);
        check("m_wrap_y", m_y, 0);
        check("m_wrap_fs", m_fs, 1);
        check("m_wrap_ls", m_ls, 1);
        check("m_wrap_fc", m_fc, 1);
        check("m_wrap_vs", m_vs, 1);
        check("m_wrap_de", m_de, 1);
        step();
        check("m_fs_drop", m_fs, 0);
        check("m_ls_drop", m_ls, 0);
        check("m_fc_hold", m_fc, 1);
        rst_m = 1'b1;

        // frame_count wrap on the tiny raster: 256 frame starts
        rst_s = 1'b0;
        step();
        check("s_rel_x", s_x, 1);
        check("s_rel_y", s_y, 0);
        sx  = 1;
        sy  = 0;
        sfc = '0;
        repeat (8958) small_step();
        check("s_fc_255", s_fc, 255);
        small_step();
        check("s_fc_wrap", s_fc, 0);
        check("s_fs_256", s_fs, 1);
        check("s_ls_256", s_ls, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
